// File: rtl/xbar_config_loader.sv
// ---------------------------------------------------------------------------
// xbar_config_loader
//
// Loads the selector settings of the LUT-tile crossbar over a word-serial
// valid/ready stream. Words collect in a shadow register. After the last word,
// the whole configuration is checked and then committed atomically to
// io_mux_configs, so the crossbar never sees a half-written configuration.
//
// Optional feature macro: XBAR_CFG_RANGE_CHECK_EN
//   defined   - a load is rejected if any selector field is >= N_IN.
//               A rejected load sets io_error and does not commit.
//   undefined - every load commits and io_error stays 0.
//
// Ports:
//   clk            in   rising-edge clock
//   reset          in   synchronous, active-high
//   io_start       in   one-cycle request to begin a load (ignored while busy)
//   io_cfg_valid   in   stream word valid
//   io_cfg_ready   out  loader accepts a word (high only in LOAD)
//   io_cfg_data    in   stream word, WORD_W bits; word 0 fills the low bits
//   io_busy        out  high in every state except IDLE
//   io_done        out  one-cycle pulse in the first IDLE cycle after COMMIT
//   io_error       out  sticky reject flag, cleared by an accepted io_start
//   io_cfg_epoch   out  count of successful commits, wraps at 256
//   io_mux_configs out  active crossbar configuration, CFG_W bits
// ---------------------------------------------------------------------------
module xbar_config_loader #(
    parameter int N_IN    = 23,
    parameter int N_OUT   = 30,
    parameter int SEL_W   = 5,
    parameter int WORD_W  = 10,
    parameter int CFG_W   = N_OUT * SEL_W,
    parameter int N_WORDS = CFG_W / WORD_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              io_start,
    input  logic              io_cfg_valid,
    output logic              io_cfg_ready,
    input  logic [WORD_W-1:0] io_cfg_data,
    output logic              io_busy,
    output logic              io_done,
    output logic              io_error,
    output logic [7:0]        io_cfg_epoch,
    output logic [CFG_W-1:0]  io_mux_configs
);

    localparam int CNT_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_CHECK  = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
    logic [CFG_W-1:0]   shadow_q, shadow_d;
    logic [CFG_W-1:0]   cfg_q, cfg_d;
    logic [7:0]         epoch_q, epoch_d;
    logic               chk_ok_q, chk_ok_d;
    logic               error_q, error_d;
    logic               done_q, done_d;
    logic               ready_q, ready_d;
    logic               hs;

    // True when every selector field addresses an existing crossbar input.
    function automatic logic sel_in_range(input logic [CFG_W-1:0] cfg);
        logic ok;
        ok = 1'b1;
        for (int k = 0; k < N_OUT; k++) begin
            if (int'(cfg[k*SEL_W +: SEL_W]) >= N_IN) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

    // ready is a registered copy of "next state is LOAD", so a handshake can
    // only ever happen while the FSM sits in LOAD.
    assign hs = io_cfg_valid && ready_q;

    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        shadow_d   = shadow_q;
        cfg_d      = cfg_q;
        epoch_d    = epoch_q;
        chk_ok_d   = chk_ok_q;
        error_d    = error_q;
        done_d     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (io_start) begin
                    state_d    = ST_LOAD;
                    word_cnt_d = '0;
                    error_d    = 1'b0;
                end
            end
            ST_LOAD: begin
                if (hs) begin
                    shadow_d[int'(word_cnt_q)*WORD_W +: WORD_W] = io_cfg_data;
                    word_cnt_d = word_cnt_q + 1'b1;
                    if (word_cnt_q == CNT_W'(N_WORDS - 1)) begin
                        state_d = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
`ifdef XBAR_CFG_RANGE_CHECK_EN
                chk_ok_d = sel_in_range(shadow_q);
`else
                chk_ok_d = 1'b1;
`endif
                state_d = ST_COMMIT;
            end
            ST_COMMIT: begin
                if (chk_ok_q) begin
                    cfg_d   = shadow_q;
                    epoch_d = epoch_q + 8'd1;
                end else begin
                    error_d = 1'b1;
                end
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        ready_d = (state_d == ST_LOAD);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            word_cnt_q <= '0;
            shadow_q   <= '0;
            cfg_q      <= '0;
            epoch_q    <= '0;
            chk_ok_q   <= 1'b0;
            error_q    <= 1'b0;
            done_q     <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            shadow_q   <= shadow_d;
            cfg_q      <= cfg_d;
            epoch_q    <= epoch_d;
            chk_ok_q   <= chk_ok_d;
            error_q    <= error_d;
            done_q     <= done_d;
            ready_q    <= ready_d;
        end
    end

    assign io_cfg_ready   = ready_q;
    assign io_busy        = (state_q != ST_IDLE);
    assign io_done        = done_q;
    assign io_error       = error_q;
    assign io_cfg_epoch   = epoch_q;
    assign io_mux_configs = cfg_q;

endmodule
